axi_stream_extract_header: RTL and testbench

// - Receive-side counterpart to axi_stream_insert_header: removes a per-packet header of 0..DATA_BYTE_WD bytes from the front of an AXI-Stream packet.
// - Presents the removed header on a separate handshaked port.
// - Re-aligns the remaining payload so every output beat is full except the last.
// - Sits downstream of the header-insert stage, between the link and the payload consumer.

---
 rtl/axi_stream_extract_header.sv | 205 ++++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header.sv
// Strips a 0..DATA_BYTE_WD byte header from each AXI-Stream packet,
// presenting it on a side port and re-packing the payload into full beats.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_in,
    input  logic [DATA_WD-1:0]              data_in,
    input  logic [DATA_BYTE_WD-1:0]         keep_in,
    input  logic                            last_in,
    output logic                            ready_in,
    input  logic                            valid_strip,
    input  logic [$clog2(DATA_BYTE_WD):0]   strip_len,
    output logic                            ready_strip,
    output logic                            valid_header,
    output logic [DATA_WD-1:0]              header_out,
    output logic [DATA_BYTE_WD-1:0]         keep_header,
    input  logic                            ready_header,
    output logic                            valid_out,
    output logic [DATA_WD-1:0]              data_out,
    output logic [DATA_BYTE_WD-1:0]         keep_out,
    output logic                            last_out,
    input  logic                            ready_out
);

    localparam int BW = DATA_BYTE_WD;
    localparam int CW = $clog2(DATA_BYTE_WD) + 1;
    localparam logic [CW-1:0] BW_C = CW'(BW);
    localparam logic [CW:0]   BW_S = (CW + 1)'(BW);

    typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       s_q, s_d;
    logic                hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]  hdr_data_q, hdr_data_d;
    logic [BW-1:0]       hdr_keep_q, hdr_keep_d;
    logic [DATA_WD-1:0]  res_data_q, res_data_d;
    logic [CW-1:0]       res_cnt_q, res_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]  out_data_q, out_data_d;
    logic [BW-1:0]       out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;

    logic [DATA_WD-1:0]  din;
    logic [CW-1:0]       n_in, h_len, r_first;
    logic [CW:0]         sum;
    logic                out_free, hdr_free, fire_in;

    function automatic logic [CW-1:0] popcnt(input logic [BW-1:0] k);
        popcnt = '0;
        for (int i = 0; i < BW; i++) popcnt = popcnt + CW'(k[i]);
    endfunction

    function automatic logic [BW-1:0] top_keep(input logic [CW-1:0] k);
        top_keep = ~({BW{1'b1}} >> k);
    endfunction

    function automatic logic [DATA_WD-1:0] keep_mask(input logic [BW-1:0] k);
        keep_mask = '0;
        for (int i = 0; i < BW; i++) keep_mask[8*i +: 8] = {8{k[i]}};
    endfunction

    function automatic logic [DATA_WD-1:0] shl(input logic [DATA_WD-1:0] d,
                                               input logic [CW-1:0] b);
        shl = d << {b, 3'b000};
    endfunction

    function automatic logic [DATA_WD-1:0] shr(input logic [DATA_WD-1:0] d,
                                               input logic [CW-1:0] b);
        shr = d >> {b, 3'b000};
    endfunction

    // Bytes outside keep are zeroed so residual/flush beats carry no stale data
    assign din     = data_in & keep_mask(keep_in);
    assign n_in    = popcnt(keep_in);
    assign h_len   = (n_in < s_q) ? n_in : s_q;
    assign r_first = (n_in > s_q) ? n_in - s_q : '0;
    assign sum     = {1'b0, res_cnt_q} + {1'b0, n_in};

    assign out_free    = !out_valid_q || ready_out;
    assign hdr_free    = !hdr_valid_q || ready_header;
    assign ready_in    = !rst && out_free &&
                         ((state_q == FIRST && hdr_free) || state_q == BODY);
    assign ready_strip = !rst && state_q == IDLE && !out_valid_q;
    assign fire_in     = valid_in && ready_in;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        hdr_valid_d = hdr_valid_q && !ready_header;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;
        res_data_d  = res_data_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = out_valid_q && !ready_out;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            IDLE: begin
                if (valid_strip && ready_strip) begin
                    s_d     = strip_len;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (fire_in) begin
                    hdr_valid_d = 1'b1;
                    hdr_keep_d  = top_keep(h_len);
                    hdr_data_d  = din & keep_mask(top_keep(h_len));
                    if (s_q == '0) begin
                        // Nothing to strip: forward the beat without waiting
                        out_valid_d = 1'b1;
                        out_data_d  = din;
                        out_keep_d  = keep_in;
                        out_last_d  = last_in;
                        res_data_d  = '0;
                        res_cnt_d   = '0;
                        state_d     = last_in ? IDLE : BODY;
                    end else begin
                        res_data_d = shl(din, s_q);
                        res_cnt_d  = r_first;
                        if (last_in)
                            state_d = (r_first != '0) ? FLUSH : IDLE;
                        else
                            state_d = BODY;
                    end
                end
            end
            BODY: begin
                if (fire_in) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_data_q | shr(din, res_cnt_q);
                    if (last_in && sum <= BW_S) begin
                        out_keep_d = top_keep(sum[CW-1:0]);
                        out_last_d = 1'b1;
                        res_data_d = '0;
                        res_cnt_d  = '0;
                        state_d    = IDLE;
                    end else begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        res_data_d = shl(din, BW_C - res_cnt_q);
                        if (last_in) begin
                            res_cnt_d = CW'(sum - BW_S);
                            state_d   = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_data_q;
                    out_keep_d  = top_keep(res_cnt_q);
                    out_last_d  = 1'b1;
                    res_data_d  = '0;
                    res_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
            res_data_q  <= res_data_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign valid_header = hdr_valid_q;
    assign header_out   = hdr_data_q;
    assign keep_header  = hdr_keep_q;
    assign valid_out    = out_valid_q;
    assign data_out     = out_data_q;
    assign keep_out     = out_keep_q;
    assign last_out     = out_last_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header (DATA_WD = 32).
// Captures header/payload handshakes at negedge and compares to hand-computed beats.
module tb_axi_stream_extract_header;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_strip;
    logic [2:0]  strip_len;
    logic        ready_strip;
    logic        valid_header;
    logic [31:0] header_out;
    logic [3:0]  keep_header;
    logic        ready_header;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .ready_in(ready_in),
        .valid_strip(valid_strip), .strip_len(strip_len),
        .ready_strip(ready_strip),
        .valid_header(valid_header), .header_out(header_out),
        .keep_header(keep_header), .ready_header(ready_header),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
        .last_out(last_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } hdr_t;

    beat_t out_q[$];
    hdr_t  hdr_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stall_err = 0;
    int    cyc = 0;
    bit    stall_en = 0;

    logic        pv = 1'b0;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && pv && (valid_out !== 1'b1 || data_out !== pd ||
                           keep_out !== pk || last_out !== pl))
            stall_err++;
        pv = valid_out && !ready_out && !rst;
        pd = data_out;
        pk = keep_out;
        pl = last_out;
        if (valid_out && ready_out) out_q.push_back('{data_out, keep_out, last_out});
        if (valid_header && ready_header) hdr_q.push_back('{header_out, keep_header});
    end

    function automatic logic [31:0] kmask(input logic [3:0] k);
        kmask = {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    task automatic send_strip(input logic [2:0] s);
        bit done = 0;
        valid_strip = 1'b1;
        strip_len   = s;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (ready_strip) done = 1;
            @(posedge clk);
            #1;
        end
        valid_strip = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL strip_handshake: ready_strip never high, required 1");
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit done = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (ready_in) done = 1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL beat_accept: beat %h not accepted, required accept", d);
        end
    endtask

    task automatic wait_out(input int no, input int nh);
        int t = 0;
        while ((out_q.size() < no || hdr_q.size() < nh) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_q.size() != no || hdr_q.size() != nh) begin
            errors++;
            $display("FAIL beat_count: got %0d payload/%0d header, required %0d/%0d",
                     out_q.size(), hdr_q.size(), no, nh);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 0; data_in = '0; keep_in = '0; last_in = 0;
        valid_strip = 0; strip_len = '0;
        ready_header = 1'b1; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({valid_out, valid_header, ready_in, ready_strip} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000",
                     {valid_out, valid_header, ready_in, ready_strip});
        end
        checks++;
        if ({data_out, header_out} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h, required 0", data_out, header_out);
        end
        checks++;
        if ({keep_out, keep_header, last_out} !== 9'h0) begin
            errors++;
            $display("FAIL reset_keep: got %b %b %b, required 0", keep_out, keep_header, last_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ready_strip !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready_strip: got %b, required 1", ready_strip);
        end
    endtask

    task automatic test_strip2();
        out_q.delete(); hdr_q.delete();
        send_strip(3'd2);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL s2_latency_early: valid_out %b, required 0", valid_out);
        end
        send_beat(32'h11223344, 4'b1111, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hCCDD1122) begin
            errors++;
            $display("FAIL s2_latency: valid_out %b data %h, required 1 CCDD1122", valid_out, data_out);
        end
        send_beat(32'h5566FFFF, 4'b1100, 1'b1);
        wait_out(2, 1);
        checks++;
        if (hdr_q[0] !== {32'hAABB0000, 4'b1100}) begin
            errors++;
            $display("FAIL s2_header: got %h/%b, required AABB0000/1100", hdr_q[0].d, hdr_q[0].k);
        end
        checks++;
        if (out_q[0] !== {32'hCCDD1122, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL s2_beat0: got %h/%b/%b, required CCDD1122/1111/0", out_q[0].d, out_q[0].k, out_q[0].l);
        end
        checks++;
        if (out_q[1] !== {32'h33445566, 4'b1111, 1'b1}) begin
            errors++;
            $display("FAIL s2_beat1: got %h/%b/%b, required 33445566/1111/1", out_q[1].d, out_q[1].k, out_q[1].l);
        end
    endtask

    task automatic test_strip1_flush();
        out_q.delete(); hdr_q.delete();
        send_strip(3'd1);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b1);
        wait_out(2, 1);
        checks++;
        if (hdr_q[0] !== {32'h01000000, 4'b1000}) begin
            errors++;
            $display("FAIL s1_header: got %h/%b, required 01000000/1000", hdr_q[0].d, hdr_q[0].k);
        end
        checks++;
        if (out_q[0] !== {32'h02030405, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL s1_beat0: got %h/%b/%b, required 02030405/1111/0", out_q[0].d, out_q[0].k, out_q[0].l);
        end
        checks++;
        if ((out_q[1].d & kmask(out_q[1].k)) !== 32'h06070800 ||
            out_q[1].k !== 4'b1110 || out_q[1].l !== 1'b1) begin
            errors++;
            $display("FAIL s1_flush: got %h/%b/%b, required 060708xx/1110/1", out_q[1].d, out_q[1].k, out_q[1].l);
        end
    endtask

    task automatic test_strip_full();
        out_q.delete(); hdr_q.delete();
        send_strip(3'd4);
        send_beat(32'hAABBCCDD, 4'b1100, 1'b1);
        checks++;
        if (ready_strip !== 1'b1) begin
            errors++;
            $display("FAIL s4_next_strip: ready_strip %b, required 1", ready_strip);
        end
        wait_out(0, 1);
        checks++;
        if (hdr_q[0] !== {32'hAABB0000, 4'b1100}) begin
            errors++;
            $display("FAIL s4_header: got %h/%b, required AABB0000/1100", hdr_q[0].d, hdr_q[0].k);
        end
    endtask

    task automatic test_strip0_passthrough();
        logic [31:0] d[4];
        int c0;
        d[0] = 32'h10203040; d[1] = 32'h50607080;
        d[2] = 32'h90A0B0C0; d[3] = 32'hD0E0F001;
        out_q.delete(); hdr_q.delete();
        send_strip(3'd0);
        c0 = cyc;
        send_beat(d[0], 4'b1111, 1'b0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== d[0]) begin
            errors++;
            $display("FAIL s0_latency: valid_out %b data %h, required 1 %h", valid_out, data_out, d[0]);
        end
        for (int i = 1; i < 4; i++) send_beat(d[i], 4'b1111, i == 3);
        checks++;
        if (cyc - c0 != 4) begin
            errors++;
            $display("FAIL s0_throughput: %0d clks for 4 beats, required 4", cyc - c0);
        end
        wait_out(4, 1);
        checks++;
        if (hdr_q[0] !== {32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL s0_header: got %h/%b, required 00000000/0000", hdr_q[0].d, hdr_q[0].k);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_q[i] !== {d[i], 4'b1111, i == 3}) begin
                errors++;
                $display("FAIL s0_beat%0d: got %h/%b/%b, required %h/1111/%0d",
                         i, out_q[i].d, out_q[i].k, out_q[i].l, d[i], i == 3);
            end
        end
    endtask

    task automatic test_backpressure();
        int viol = 0;
        out_q.delete(); hdr_q.delete();
        stall_err = 0;
        ready_header = 1'b0;
        stall_en = 1'b1;
        fork
            begin
                while (stall_en) begin
                    @(posedge clk);
                    #1;
                    ready_out = 1'($urandom_range(0, 1));
                end
                ready_out = 1'b1;
            end
        join_none
        send_strip(3'd2);
        send_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
        send_beat(32'hB0B1B2B3, 4'b1111, 1'b0);
        send_beat(32'hC0C1EEEE, 4'b1100, 1'b1);
        wait_out(2, 0);
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_header !== 1'b1 || header_out !== 32'hA0A10000) begin
            errors++;
            $display("FAIL bp_header_hold: valid %b data %h, required 1 A0A10000", valid_header, header_out);
        end
        send_strip(3'd1);
        fork
            send_beat(32'hD0D1D2D3, 4'b1111, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (ready_in) viol++;
                end
                @(posedge clk);
                #1;
                ready_header = 1'b1;
            end
        join
        wait_out(3, 2);
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL bp_ready_in_blocked: ready_in high %0d clks, required 0", viol);
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d outputs changed while stalled, required 0", stall_err);
        end
        checks++;
        if (hdr_q[0] !== {32'hA0A10000, 4'b1100} || hdr_q[1] !== {32'hD0000000, 4'b1000}) begin
            errors++;
            $display("FAIL bp_headers: got %h/%b %h/%b, required A0A10000/1100 D0000000/1000",
                     hdr_q[0].d, hdr_q[0].k, hdr_q[1].d, hdr_q[1].k);
        end
        checks++;
        if (out_q[0] !== {32'hA2A3B0B1, 4'b1111, 1'b0} ||
            out_q[1] !== {32'hB2B3C0C1, 4'b1111, 1'b1}) begin
            errors++;
            $display("FAIL bp_payload_a: got %h %h, required A2A3B0B1 B2B3C0C1(last)",
                     out_q[0].d, out_q[1].d);
        end
        checks++;
        if ((out_q[2].d & kmask(out_q[2].k)) !== 32'hD1D2D300 ||
            out_q[2].k !== 4'b1110 || out_q[2].l !== 1'b1) begin
            errors++;
            $display("FAIL bp_payload_b: got %h/%b/%b, required D1D2D3xx/1110/1",
                     out_q[2].d, out_q[2].k, out_q[2].l);
        end
    endtask

    task automatic test_reset_mid_packet();
        ready_out = 1'b1;
        ready_header = 1'b1;
        send_strip(3'd1);
        send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
        send_beat(32'h11111111, 4'b1111, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({valid_out, valid_header} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_valids: got %b, required 00", {valid_out, valid_header});
        end
        out_q.delete(); hdr_q.delete();
        send_strip(3'd2);
        send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
        send_beat(32'hB1B2B3B4, 4'b1111, 1'b1);
        wait_out(2, 1);
        checks++;
        if (hdr_q[0] !== {32'hA1A20000, 4'b1100}) begin
            errors++;
            $display("FAIL rst_mid_header: got %h/%b, required A1A20000/1100", hdr_q[0].d, hdr_q[0].k);
        end
        checks++;
        if (out_q[0] !== {32'hA3A4B1B2, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_beat0: got %h/%b/%b, required A3A4B1B2/1111/0", out_q[0].d, out_q[0].k, out_q[0].l);
        end
        checks++;
        if ((out_q[1].d & kmask(out_q[1].k)) !== 32'hB3B40000 ||
            out_q[1].k !== 4'b1100 || out_q[1].l !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_beat1: got %h/%b/%b, required B3B4xxxx/1100/1", out_q[1].d, out_q[1].k, out_q[1].l);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_strip2();
        test_strip1_flush();
        test_strip_full();
        test_strip0_passthrough();
        test_backpressure();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
